// File: rtl/divider_taint_track_bitwise.sv
`default_nettype none
// ============================================================================
// Module      : divider_taint_track_bitwise
// Description : Constant-time sequential restoring divider (MSB first, one
//               step per cycle) with conservative per-bit taint tracking of
//               quotient and remainder. Taint datapath is compiled in only
//               when DIVIDER_TAINT_TRACK_EN is defined; otherwise the taint
//               outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_taint_track_bitwise #(
  parameter int NUM_BITS = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] dividend,
  input  logic [NUM_BITS-1:0] divisor,
  input  logic [NUM_BITS-1:0] dividend_taint,
  input  logic [NUM_BITS-1:0] divisor_taint,
  output logic [NUM_BITS-1:0] quotient,
  output logic [NUM_BITS-1:0] remainder,
  output logic [NUM_BITS-1:0] quotient_taint,
  output logic [NUM_BITS-1:0] remainder_taint,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_BITS-1:0] dvd_q, dvd_d;   // dividend, shifted left each step
  logic [NUM_BITS-1:0] dvs_q, dvs_d;
  logic [NUM_BITS-1:0] quo_q, quo_d;
  logic [NUM_BITS-1:0] rem_q, rem_d;   // partial remainder doubles as output

  logic                w_launch;
  logic [NUM_BITS:0]   w_p_shift;
  logic                w_ge;
  logic [NUM_BITS-1:0] w_diff;

  // start is honoured only outside CALC, which also gives back-to-back launch from DONE
  assign w_launch  = start && (state_q != S_CALC);

  // Compare and subtract are evaluated every cycle; the result is only muxed
  assign w_p_shift = {rem_q, dvd_q[NUM_BITS-1]};
  assign w_ge      = (w_p_shift >= {1'b0, dvs_q});
  // When w_ge holds the true difference is below the divisor, so it fits NUM_BITS
  assign w_diff    = w_p_shift[NUM_BITS-1:0] - dvs_q;

  // Next-state and arithmetic datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    if (w_launch) begin
      state_d = S_CALC;
      cnt_d   = '0;
      dvd_d   = dividend;
      dvs_d   = divisor;
      quo_d   = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        S_CALC: begin
          dvd_d = dvd_q << 1;
          quo_d = NUM_BITS'({quo_q, w_ge});
          rem_d = w_ge ? w_diff : w_p_shift[NUM_BITS-1:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and arithmetic registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = (state_q == S_CALC);
  assign done      = (state_q == S_DONE);

`ifdef DIVIDER_TAINT_TRACK_EN
  logic [NUM_BITS-1:0] dvdt_q, dvdt_d;  // dividend taint, shifted with dividend
  logic                dvst_q, dvst_d;  // any divisor bit tainted
  logic [NUM_BITS-1:0] qt_q, qt_d;
  logic [NUM_BITS-1:0] t_q, t_d;
  logic [NUM_BITS-1:0] w_t_shift;
  logic                w_qt;

  assign w_t_shift = NUM_BITS'({t_q, dvdt_q[NUM_BITS-1]});
  assign w_qt      = (|w_t_shift) | dvst_q;

  // Taint step: a tainted quotient bit saturates the remainder taint to all ones
  always_comb begin
    dvdt_d = dvdt_q;
    dvst_d = dvst_q;
    qt_d   = qt_q;
    t_d    = t_q;
    if (w_launch) begin
      dvdt_d = dividend_taint;
      dvst_d = |divisor_taint;
      qt_d   = '0;
      t_d    = '0;
    end else if (state_q == S_CALC) begin
      dvdt_d = dvdt_q << 1;
      qt_d   = NUM_BITS'({qt_q, w_qt});
      t_d    = w_qt ? '1 : w_t_shift;
    end
  end

  // Taint registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dvdt_q <= '0;
      dvst_q <= 1'b0;
      qt_q   <= '0;
      t_q    <= '0;
    end else begin
      dvdt_q <= dvdt_d;
      dvst_q <= dvst_d;
      qt_q   <= qt_d;
      t_q    <= t_d;
    end
  end

  assign quotient_taint  = qt_q;
  assign remainder_taint = t_q;
`else
  logic unused_taint;
  assign unused_taint    = ^{dividend_taint, divisor_taint};
  assign quotient_taint  = '0;
  assign remainder_taint = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_divider_taint_track_bitwise.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_taint_track_bitwise
// Description : Scoreboard bench for divider_taint_track_bitwise. Stimulus
//               pushes expected results (with expected done cycle); a monitor
//               pops and compares whenever done is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_taint_track_bitwise;

  localparam int N = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend, divisor, dividend_taint, divisor_taint;
  logic [N-1:0] quotient, remainder, quotient_taint, remainder_taint;
  logic         busy, done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic [N-1:0] qt;
    logic [N-1:0] rt;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  divider_taint_track_bitwise #(.NUM_BITS(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .dividend        (dividend),
    .divisor         (divisor),
    .dividend_taint  (dividend_taint),
    .divisor_taint   (divisor_taint),
    .quotient        (quotient),
    .remainder       (remainder),
    .quotient_taint  (quotient_taint),
    .remainder_taint (remainder_taint),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain division; taint is a quotient bit tainted iff any tainted
  // dividend bit sits at or above it (or any divisor bit is tainted), and the
  // remainder is fully tainted as soon as anything is tainted.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [N-1:0] at, input logic [N-1:0] bt,
                                 input int c);
    exp_t m;
    m.q   = (b == 0) ? {N{1'b1}} : N'(a / b);
    m.r   = (b == 0) ? a : N'(a % b);
    m.qt  = '0;
    m.rt  = '0;
    m.cyc = c;
`ifdef DIVIDER_TAINT_TRACK_EN
    if (bt != 0) begin
      m.qt = {N{1'b1}};
      m.rt = {N{1'b1}};
    end else begin
      for (int i = 0; i < N; i++) m.qt[i] = ((at >> i) != 0);
      m.rt = (at != 0) ? {N{1'b1}} : '0;
    end
`endif
    return m;
  endfunction

  // Monitor: compare every done against the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("busy_during_done", int'(busy), 0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("quotient_taint", int'(quotient_taint), int'(e.qt));
        chk("remainder_taint", int'(remainder_taint), int'(e.rt));
      end
    end
  end

  // Drives one operation from the current negedge; returns at the DONE negedge
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] at, input logic [N-1:0] bt,
                       input bit junk);
    dividend       = a;
    divisor        = b;
    dividend_taint = at;
    divisor_taint  = bt;
    start          = 1'b1;
    sb.push_back(model(a, b, at, bt, cyc + 1 + N));
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < N; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (junk && j == 1) begin
        start          = 1'b1;
        dividend       = N'($urandom);
        divisor        = N'($urandom);
        dividend_taint = N'($urandom);
        divisor_taint  = N'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_quotient"}, int'(quotient), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_quotient_taint"}, int'(quotient_taint), 0);
    chk({tag, "_remainder_taint"}, int'(remainder_taint), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] a, b, at, bt;
    rst = 1'b1; start = 1'b0;
    dividend = '0; divisor = '0; dividend_taint = '0; divisor_taint = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 100/7 clean
    issue(7'd100, 7'd7, 7'd0, 7'd0, 1'b0);
    @(negedge clk);
    // back-to-back 127/1 then 45/0
    issue(7'd127, 7'd1, 7'd0, 7'd0, 1'b0);
    issue(7'd45, 7'd0, 7'd0, 7'd0, 1'b0);
    @(negedge clk);
    // divisor taint and dividend taint
    issue(7'd45, 7'd9, 7'd0, 7'b0000001, 1'b0);
    @(negedge clk);
    issue(7'd45, 7'd9, 7'b0000001, 7'd0, 1'b0);
    @(negedge clk);

    // reset three cycles into CALC aborts with no done
    dividend = 7'd100; divisor = 7'd7; dividend_taint = '0; divisor_taint = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("abort");
    repeat (N + 3) @(negedge clk);
    issue(7'd100, 7'd7, 7'd0, 7'd0, 1'b0);
    @(negedge clk);

    // start mid-CALC with new operands is ignored
    issue(7'd100, 7'd7, 7'd0, 7'd0, 1'b1);
    @(negedge clk);

    // randomized operations, mixed gaps and back-to-back
    for (int i = 0; i < 40; i++) begin
      a  = N'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      at = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      bt = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      issue(a, b, at, bt, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
